// File: rtl/pool_pkg.sv
// Shared types and helpers for the ReLU + 2x2 max-pool stage.
//   DATA_W       : default signed data width of convolution results
//   data_t       : signed data word
//   pool_state_t : frame sequencing state (IDLE between frames, RUN inside one)
//   smax         : signed maximum of two data words (result is always an input)
package pool_pkg;

    localparam int DATA_W = 8;

    typedef logic signed [DATA_W-1:0] data_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pool_state_t;

    function automatic data_t smax(input data_t a, input data_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Half-row line buffer holding the pairwise max of the top row of each
// 2x2 window until the bottom row arrives.
//   clk   : clock
//   we    : write enable
//   idx   : entry index, shared by the write and read ports
//   wdata : data written at idx when we=1
//   rdata : combinational read of entry idx
// Contents are not reset: every entry is written on an even row before it
// is read on the following odd row.
module pool_line_buf
    import pool_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  data_t            wdata,
    output data_t            rdata
);

    data_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/relu_maxpool.sv
// Streaming ReLU followed by 2x2 / stride-2 max pooling over a square ofmap
// delivered one pixel per conv_valid in raster order. No backpressure.
//   clk, rst_n   : clock, asynchronous active-low reset
//   ofmap_size   : ofmap width = height, sampled on the first pixel of a frame
//   relu_en      : clamp negatives to zero, sampled on the first pixel of a frame
//   conv_valid   : conv_result valid this cycle
//   conv_result  : signed convolution result
//   pool_valid   : one-cycle pulse, pool_result carries a new pooled value
//   pool_result  : signed pooled value, held until the next pool_valid
//   frame_done   : one-cycle pulse after the last pixel of a frame
//   size_err     : the current/last frame's size is <2 or >MAX_OFMAP_W
module relu_maxpool #(
    parameter int DATA_W      = pool_pkg::DATA_W,
    parameter int MAX_OFMAP_W = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [9:0]               ofmap_size,
    input  logic                     relu_en,
    input  logic                     conv_valid,
    input  logic signed [DATA_W-1:0] conv_result,
    output logic                     pool_valid,
    output logic signed [DATA_W-1:0] pool_result,
    output logic                     frame_done,
    output logic                     size_err
);

    import pool_pkg::*;

    localparam int LB_DEPTH = MAX_OFMAP_W / 2;
    localparam int IDX_W    = $clog2(LB_DEPTH);

    pool_state_t state;
    logic [9:0]  sz;
    logic        re;
    logic [9:0]  row;
    logic [9:0]  col;
    data_t       hold;

    logic        starting;
    logic [9:0]  eff_sz;
    logic        eff_re;
    logic        eff_err;
    data_t       v;
    logic        last_col;
    logic        last_px;
    logic        lb_we;
    logic        pool_hit;
    data_t       lb_rdata;

    // The first pixel of a frame is processed with the live inputs, since
    // sz/re/size_err only take those values at the end of that cycle.
    always_comb begin
        starting = (state == IDLE);
        eff_sz   = starting ? ofmap_size : sz;
        eff_re   = starting ? relu_en : re;
        eff_err  = starting ? ((ofmap_size < 10'd2) || (ofmap_size > 10'(MAX_OFMAP_W)))
                            : size_err;
        v        = (eff_re && (conv_result < 0)) ? '0 : conv_result;
        last_col = (col == eff_sz - 10'd1);
        // Sizes 0 and 1 both make a one-pixel frame.
        last_px  = (eff_sz < 10'd2) || (last_col && (row == eff_sz - 10'd1));
        // With odd sizes the trailing even column/row never satisfies these.
        lb_we    = conv_valid && !eff_err && col[0] && !row[0];
        pool_hit = conv_valid && !eff_err && col[0] && row[0];
    end

    pool_line_buf #(
        .DEPTH (LB_DEPTH),
        .IDX_W (IDX_W)
    ) u_line_buf (
        .clk   (clk),
        .we    (lb_we),
        .idx   (col[IDX_W:1]),
        .wdata (smax(hold, v)),
        .rdata (lb_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sz          <= '0;
            re          <= 1'b0;
            row         <= '0;
            col         <= '0;
            hold        <= '0;
            pool_valid  <= 1'b0;
            pool_result <= '0;
            frame_done  <= 1'b0;
            size_err    <= 1'b0;
        end else begin
            pool_valid <= 1'b0;
            frame_done <= 1'b0;
            if (conv_valid) begin
                if (starting) begin
                    sz       <= ofmap_size;
                    re       <= relu_en;
                    size_err <= eff_err;
                end
                if (!col[0]) begin
                    hold <= v;
                end
                if (pool_hit) begin
                    pool_valid  <= 1'b1;
                    pool_result <= smax(smax(lb_rdata, hold), v);
                end
                if (last_px) begin
                    state      <= IDLE;
                    row        <= '0;
                    col        <= '0;
                    frame_done <= 1'b1;
                end else begin
                    state <= RUN;
                    if (last_col) begin
                        col <= '0;
                        row <= row + 10'd1;
                    end else begin
                        col <= col + 10'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_relu_maxpool.sv
// Directed self-checking bench for relu_maxpool. Inputs are driven on the
// falling edge; outputs are sampled on the next falling edge, i.e. half a
// cycle after the rising edge that registered them.
module tb_relu_maxpool;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [9:0]          ofmap_size;
    logic                relu_en;
    logic                conv_valid;
    logic signed [7:0]   conv_result;
    logic                pool_valid;
    logic signed [7:0]   pool_result;
    logic                frame_done;
    logic                size_err;

    int errors = 0;
    int checks = 0;

    int din [16];
    bit epv [16];
    int epr [16];

    relu_maxpool #(
        .DATA_W      (8),
        .MAX_OFMAP_W (64)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ofmap_size  (ofmap_size),
        .relu_en     (relu_en),
        .conv_valid  (conv_valid),
        .conv_result (conv_result),
        .pool_valid  (pool_valid),
        .pool_result (pool_result),
        .frame_done  (frame_done),
        .size_err    (size_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic signed [31:0] got,
                            input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 16; i++) begin
            din[i] = 0;
            epv[i] = 1'b0;
            epr[i] = 0;
        end
    endtask

    task automatic load4(input bit re);
        int d [16] = '{1, 2, 3, 4, 5, -6, 7, 8, -1, -2, -3, -4, -5, -6, -7, -8};
        clear_exp();
        for (int i = 0; i < 16; i++) din[i] = d[i];
        epv[5] = 1'b1;  epr[5] = 5;
        epv[7] = 1'b1;  epr[7] = 8;
        epv[13] = 1'b1; epr[13] = re ? 0 : -1;
        epv[15] = 1'b1; epr[15] = re ? 0 : -3;
    endtask

    task automatic load3();
        clear_exp();
        for (int i = 0; i < 9; i++) din[i] = i + 1;
        epv[4] = 1'b1; epr[4] = 5;
    endtask

    task automatic load2();
        clear_exp();
        din[0] = 9; din[1] = -1; din[2] = 3; din[3] = 4;
        epv[3] = 1'b1; epr[3] = 9;
    endtask

    task automatic pix(input string tag, input int v, input bit exp_pv,
                       input int exp_pr, input bit exp_fd);
        conv_valid  = 1'b1;
        conv_result = v[7:0];
        @(negedge clk);
        conv_valid  = 1'b0;
        check_eq({tag, " pool_valid"}, pool_valid, exp_pv);
        if (exp_pv) check_eq({tag, " pool_result"}, pool_result, exp_pr);
        check_eq({tag, " frame_done"}, frame_done, exp_fd);
    endtask

    task automatic gap(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check_eq({tag, " gap pool_valid"}, pool_valid, 0);
            check_eq({tag, " gap frame_done"}, frame_done, 0);
        end
    endtask

    // chg_at >= 0: at that pixel, change ofmap_size to 2 and flip relu_en;
    // the frame must keep using the values sampled on its first pixel.
    task automatic run_frame(input string tag, input int size, input bit re,
                             input int npix, input int maxgap, input int chg_at,
                             input int exp_err);
        ofmap_size = size[9:0];
        relu_en    = re;
        for (int i = 0; i < npix; i++) begin
            string t;
            t = $sformatf("%s[%0d]", tag, i);
            if (i == chg_at) begin
                ofmap_size = 10'd2;
                relu_en    = !re;
            end
            if (i < 16) pix(t, din[i], epv[i], epr[i], i == npix - 1);
            else        pix(t, 0, 1'b0, 0, i == npix - 1);
            if (i == 0) check_eq({t, " size_err"}, size_err, exp_err);
            if (maxgap > 0 && i < npix - 1) gap(t, $urandom_range(0, maxgap));
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        conv_valid  = 1'b0;
        conv_result = '0;
        ofmap_size  = 10'd4;
        relu_en     = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("reset pool_valid", pool_valid, 0);
        check_eq("reset pool_result", pool_result, 0);
        check_eq("reset frame_done", frame_done, 0);
        check_eq("reset size_err", size_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        load4(1'b1); run_frame("relu4", 4, 1'b1, 16, 0, -1, 0);
        load4(1'b0); run_frame("bypass4", 4, 1'b0, 16, 0, -1, 0);
        load3();     run_frame("odd3", 3, 1'b1, 9, 0, -1, 0);
        load4(1'b1); run_frame("gaps4", 4, 1'b1, 16, 3, -1, 0);

        // Reset in the middle of a frame, right after the first pooled output.
        load4(1'b1);
        ofmap_size = 10'd4;
        relu_en    = 1'b1;
        for (int i = 0; i < 6; i++)
            pix($sformatf("part4[%0d]", i), din[i], epv[i], epr[i], 1'b0);
        rst_n = 1'b0;
        #1;
        check_eq("midrst pool_valid", pool_valid, 0);
        check_eq("midrst pool_result", pool_result, 0);
        check_eq("midrst frame_done", frame_done, 0);
        check_eq("midrst size_err", size_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_frame("after_rst4", 4, 1'b1, 16, 0, -1, 0);

        clear_exp(); run_frame("size1", 1, 1'b1, 1, 0, -1, 1);
        clear_exp(); run_frame("size0", 0, 1'b1, 1, 0, -1, 1);
        clear_exp(); run_frame("size70", 70, 1'b1, 4900, 0, -1, 1);
        load4(1'b1); run_frame("legal4", 4, 1'b1, 16, 0, -1, 0);

        load4(1'b1); run_frame("b2b_a", 4, 1'b1, 16, 0, -1, 0);
        run_frame("b2b_b", 4, 1'b1, 16, 0, 5, 0);
        load2();     run_frame("size2", 2, 1'b0, 4, 0, -1, 0);

        gap("tail", 2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/relu_maxpool.md
Name: relu_maxpool

Overview:
- Streaming ReLU + 2x2/stride-2 max-pool stage directly downstream of the accumulator.
- Consumes the accumulator's final convolution results (conv_valid/conv_result), one ofmap pixel per valid cycle in raster order.
- Emits one pooled value per 2x2 window and a per-frame done pulse.
- Has no backpressure: the accumulator's output has no ready, so this block accepts conv_valid every cycle.

Parameters:
- DATA_W, 8, signed width of conv_result and pool_result.
- MAX_OFMAP_W, 64, largest supported ofmap width; line buffer depth is MAX_OFMAP_W/2.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- ofmap_size  input  10  ofmap width = height (square), sampled at frame start
- relu_en  input  1  1: clamp negatives to 0 before pooling; 0: bypass ReLU; sampled at frame start
- conv_valid  input  1  conv_result valid this cycle
- conv_result  input  DATA_W  signed convolution result
- pool_valid  output  1  pool_result valid (single-cycle pulse)
- pool_result  output  DATA_W  signed pooled value
- frame_done  output  1  one-cycle pulse after the last pixel of a frame
- size_err  output  1  high for a frame whose sampled size is <2 or >MAX_OFMAP_W

Behaviour:
- Reset (async, rst_n=0): state=IDLE, row/col counters=0, hold register=0, pool_valid=0, pool_result=0, frame_done=0, size_err=0. Line buffer contents need no reset; they are always written before being read.
- FSM IDLE -> RUN:
  - Triggered by the first conv_valid in IDLE.
  - On that cycle, latch ofmap_size into sz and relu_en into re.
  - That pixel is processed as (row 0, col 0).
- FSM RUN -> IDLE: on the pixel with row=sz-1, col=sz-1. frame_done pulses the following cycle.
- Counters advance only on conv_valid. Idle gaps of any length between pixels are allowed and change nothing.
- Column/row wrap:
  - col wraps from sz-1 to 0 and increments row.
  - row wraps to 0 at frame end.
- Per-pixel processing, with v = re ? max(x,0) : x (signed compare):
  - even col: hold <= v.
  - even row, odd col: lbuf[col>>1] <= max(hold, v).
  - odd row, odd col: pool_result <= max(lbuf[col>>1], hold, v); pool_valid=1.
- Latency: pool_valid/pool_result are registered one cycle after the conv_valid of the window's bottom-right pixel. pool_result holds its value until the next pool_valid.
- Odd sz (floor pooling):
  - Last column (col=sz-1, even) is counted but never written to lbuf.
  - Last row (row=sz-1, even) is counted but produces no output.
  - Frame still ends after sz*sz pixels.
- size_err:
  - Set when the sampled size is <2 or >MAX_OFMAP_W.
  - The frame's pixels are still counted to sz*sz.
  - pool_valid stays suppressed and lbuf is not written.
  - Cleared on the next frame start with a legal size. frame_done still pulses.
  - sz=0 counts as 1 pixel per frame.
- ofmap_size/relu_en changes during RUN are ignored until the next IDLE.
- Max is over signed DATA_W values. No widening: the result is always one of the inputs.

Decomposition:
- Package pool_pkg:
  - DATA_W default constant.
  - typedef logic signed [DATA_W-1:0] data_t.
  - enum {IDLE, RUN} pool_state_t.
  - function smax(data_t a, data_t b).
- One sub-module, pool_line_buf: MAX_OFMAP_W/2 x DATA_W register array, one write port and one combinational read port at the same index. Write and read never target the same entry in the same cycle; this is guaranteed by row parity.

Test Plan:
- 4x4, relu_en=1, rows {1,2,3,4},{5,-6,7,8},{-1,-2,-3,-4},{-5,-6,-7,-8} back-to-back -> pool_valid one cycle after pixels 5,7,13,15 with 5,8,0,0. frame_done one cycle after pixel 15.
- Same data with relu_en=0 -> 5,8,-1,-3.
- 3x3, values 1..9, relu_en=1 -> exactly one output, 5, after pixel 4. frame_done after pixel 8; no output for col 2/row 2.
- 4x4 frame with 0-3 random idle cycles between pixels -> identical outputs to the back-to-back case. pool_valid never asserts during gaps.
- Reset asserted after 6 pixels of a 4x4 frame -> all outputs 0 immediately. A fresh full frame after release gives 5,8,0,0.
- ofmap_size=1 (then 70 with MAX 64) -> size_err=1, no pool_valid, frame_done after 1 (resp. 4900) pixels. A following legal 4x4 frame clears size_err and pools correctly.
- Two back-to-back 4x4 frames with ofmap_size changed to 2 mid-frame -> second frame still uses 4. A third frame with size 2 and values {9,-1},{3,4} -> single output 9.
